// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults for the register file
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_ADDR_W   = 5;
    // Highest index is architecturally zero: writes dropped, reads return 0.
    localparam int ZERO_REG     = DEF_NUM_REGS - 1;

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - write port and two read ports of the register file
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );

endinterface

// File: rtl/decoder_5_to_32.sv
// rtl/decoder_5_to_32.sv - two-level 5:32 enabled decoder (2:4 feeding four 3:8)
module decoder_5_to_32 (
    input  logic        enable,
    input  logic [4:0]  in,
    output logic [31:0] out
);

    logic [3:0] grp_en;

    decoder_en #(.IN_W(2)) u_hi (
        .en_i  (enable),
        .in_i  (in[4:3]),
        .out_o (grp_en)
    );

    for (genvar g = 0; g < 4; g++) begin : g_lo
        decoder_en #(.IN_W(3)) u_lo (
            .en_i  (grp_en[g]),
            .in_i  (in[2:0]),
            .out_o (out[g*8 +: 8])
        );
    end

endmodule

// File: rtl/decoder_en.sv
// rtl/decoder_en.sv - enabled binary to one-hot decoder building block
module decoder_en #(
    parameter int IN_W = 2
) (
    input  logic                 en_i,
    input  logic [IN_W-1:0]      in_i,
    output logic [2**IN_W-1:0]   out_o
);

    localparam logic [2**IN_W-1:0] ONE = {{(2**IN_W-1){1'b0}}, 1'b1};

    assign out_o = en_i ? (ONE << in_i) : '0;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 1W/2R register file with hard-wired zero in the top register
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic      clk,
    input  logic      reset_n,
    regfile_if.slave  bus
);

    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic [NUM_REGS-1:0] wr_en;
    logic [NUM_REGS-1:0] rd_sel1;
    logic [NUM_REGS-1:0] rd_sel2;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [DATA_W-1:0]   rd_data1;
    logic [DATA_W-1:0]   rd_data2;

    assign wr_addr  = bus.WriteRegister;
    assign rd_addr1 = bus.ReadRegister1;
    assign rd_addr2 = bus.ReadRegister2;

    decoder_5_to_32 u_wr_dec  (.enable(bus.RegWrite), .in(wr_addr),  .out(wr_en));
    decoder_5_to_32 u_rd1_dec (.enable(1'b1),         .in(rd_addr1), .out(rd_sel1));
    decoder_5_to_32 u_rd2_dec (.enable(1'b1),         .in(rd_addr2), .out(rd_sel2));

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en[i]) begin
                regs_d[i] = (i == ZERO_REG) ? '0 : bus.WriteData;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // AND-OR read mux driven by one-hot selects; reads see stored state only, no bypass.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data1 = rd_data1 | ({DATA_W{rd_sel1[i]}} & regs_q[i]);
            rd_data2 = rd_data2 | ({DATA_W{rd_sel2[i]}} & regs_q[i]);
        end
    end

    assign bus.ReadData1 = rd_data1;
    assign bus.ReadData2 = rd_data2;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_W, default 64, width of each register and of every data port.
REQ-002 Parameter NUM_REGS, default 32, number of architectural registers, power of two.
REQ-003 Parameter ADDR_W, default 5, register address width, equal to log2(NUM_REGS).
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1, reset: asynchronous, active-low.
REQ-006 Port RegWrite, input, 1, write enable for the single write port.
REQ-007 Port WriteRegister, input, ADDR_W, destination register index.
REQ-008 Port WriteData, input, DATA_W, data to be written.
REQ-009 Port ReadRegister1, input, ADDR_W, read port 1 index.
REQ-010 Port ReadRegister2, input, ADDR_W, read port 2 index.
REQ-011 Port ReadData1, output, DATA_W, contents selected by ReadRegister1.
REQ-012 Port ReadData2, output, DATA_W, contents selected by ReadRegister2.

Function
REQ-013 Write path: WriteRegister SHALL be decoded, gated by RegWrite, into a one-hot NUM_REGS-bit enable vector; no enable bit is set when RegWrite=0.
REQ-014 On a rising clk edge with RegWrite=1, register[WriteRegister] SHALL load WriteData; all other registers hold.
REQ-015 On a rising clk edge with RegWrite=0, no register SHALL change.
REQ-016 Register NUM_REGS-1 (X31) SHALL be hard-wired zero; writes to it are discarded and reads return 0.
REQ-017 Read ports SHALL be combinational, zero-cycle latency, and independent; both may address the same register.
REQ-018 Read-during-write to the same index SHALL return the pre-edge (old) value until the edge, then the new value; there is no write-to-read bypass.
REQ-019 Write latency: data written at edge N SHALL be visible on a read port immediately after edge N.
REQ-020 WriteData/WriteRegister changes with RegWrite=0 SHALL have no effect on state.
REQ-021 Address inputs are fully decoded; every value 0..NUM_REGS-1 is legal and no wrap or aliasing is permitted.

Reset
REQ-022 Asserting reset_n=0 SHALL clear every register to 0 immediately, without waiting for clk.
REQ-023 While reset_n=0, writes SHALL be ignored and both read ports SHALL return 0.
REQ-024 Reset asserted in the same cycle as a write SHALL win; the register reads 0 after reset release.
REQ-025 The first write after deassertion SHALL take effect at the first rising edge with reset_n=1.

Structure
REQ-026 Package regfile_pkg SHALL hold DATA_W, NUM_REGS, ADDR_W defaults and ZERO_REG = NUM_REGS-1.
REQ-027 Write-enable decode SHALL be a sub-module decoder_5_to_32 (enable, in[4:0], out[31:0]), built hierarchically from smaller enabled decoders.
REQ-028 Read selection SHALL be a NUM_REGS:1 mux per read port, DATA_W bits wide, built from the same datapath style as the decoder.

Verification
REQ-029 Reset: reset_n=0 mid-cycle after registers 0..30 are loaded with nonzero values -> all reads return 0 before the next clk edge.
REQ-030 Write/read sweep: write 64'h0000_0000_0000_0100+i to reg i for i=0..30, then read all on both ports -> each returns its value; reg 31 returns 0.
REQ-031 Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF -> ReadData1 (ReadRegister1=31) stays 0.
REQ-032 Write disable: RegWrite=0, WriteRegister=5, WriteData=64'hDEAD_BEEF -> reg 5 unchanged.
REQ-033 Read-during-write: reg 7=64'h1, same cycle write 64'h2 to reg 7 while reading 7 on both ports -> 64'h1 before edge, 64'h2 after.
REQ-034 Dual-port same address: ReadRegister1=ReadRegister2=12 holding 64'hA5A5 -> both ports return 64'hA5A5 simultaneously.
